// File: rtl/mac_accumulator.sv
// mac_accumulator: sequences 4x4 operand pairs into a multi-cycle multiplier and accumulates the products.
// Define MAC_SATURATE_EN to clamp the running sum on overflow instead of wrapping.
module mac_accumulator #(
    parameter int ACC_W   = 16,
    parameter int MUL_LAT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a_in,
    input  logic [3:0]       b_in,
    input  logic             in_last,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    output logic             mul_start,
    input  logic [7:0]       mul_result,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    output logic             overflow
);
    typedef enum logic [2:0] {IDLE, START, WAIT, ACC, DONE} state_t;
    localparam int CW = $clog2(MUL_LAT + 2);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic last;
    logic [ACC_W-1:0] sum, sum_nx;
    logic [ACC_W:0] sum_ext;
    logic accept;
    assign in_ready  = rst && state == IDLE;
    assign mul_start = rst && state == START;
    assign acc_valid = rst && state == DONE;
    assign accept    = in_valid && in_ready;
    assign sum_ext   = {1'b0, sum} + {{(ACC_W - 7){1'b0}}, mul_result};
`ifdef MAC_SATURATE_EN
    assign sum_nx = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
    assign sum_nx = sum_ext[ACC_W-1:0];
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? START : IDLE;
            START:   state_nx = cnt == CW'(1) ? WAIT : START;
            WAIT:    state_nx = cnt == '0 ? ACC : WAIT;
            ACC:     state_nx = last ? DONE : IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    // START counts up to 1, then the same counter is reloaded as the WAIT down-counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            last     <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            sum      <= '0;
            acc_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE:    cnt <= '0;
                START:   cnt <= cnt == CW'(1) ? CW'(MUL_LAT - 1) : cnt + CW'(1);
                WAIT:    cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (accept) begin
                mul_a <= a_in;
                mul_b <= b_in;
                last  <= in_last;
            end
            if (state == IDLE && clear) begin
                acc_out  <= '0;
                overflow <= 1'b0;
            end
            if (state == ACC) begin
                sum <= sum_nx;
                if (sum_ext[ACC_W]) overflow <= 1'b1;
            end
            if (state == DONE) begin
                acc_out <= sum;
                sum     <= '0;
            end
        end
    end
endmodule
